fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
Parametrised fetch-stage-0 PC generator, the multi-byte-fetch successor of the single-instruction PC register. It issues aligned fetch-block requests of FETCH_BYTES to the icache over a valid/ready channel, with a slot mask for the first valid instruction. It arbitrates backend flush against branch-predictor redirects and tags each request with an epoch. A credit counter caps the number of in-flight icache requests. It sits between the writeback/BPU redirect sources and the icache request port.

Parameters:
PC_W, 64, PC width in bits; PC arithmetic is modulo 2^PC_W.
FETCH_BYTES, 16, fetch block size in bytes; power of 2, minimum 4; SLOTS = FETCH_BYTES/4.
MAX_OUTSTANDING, 2, maximum accepted-but-unfinished icache requests; minimum 1.
EPOCH_W, 2, epoch tag width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
reset_vec_i  in  PC_W  boot PC; sampled while rst_n is low
be_redir_i  in  1  backend flush/redirect (highest priority)
be_redir_pc_i  in  PC_W  backend target
bp_redir_i  in  1  branch-predictor redirect
bp_redir_pc_i  in  PC_W  BPU target
stall_i  in  1  instruction queue full
ic_req_valid_o  out  1  fetch request valid
ic_req_ready_i  in  1  icache accepts request
ic_req_pc_o  out  PC_W  fetch PC (bits [1:0] forced to 0)
ic_req_mask_o  out  SLOTS  valid 4-byte slots in the block
ic_req_epoch_o  out  EPOCH_W  epoch tag of the request
ic_flush_o  out  1  equals be_redir_i; icache drops all in-flight requests
ic_resp_done_i  in  1  one in-flight request completed (returns a credit)

Behaviour:
- State: pc_r, epoch_r, out_cnt (0..MAX_OUTSTANDING).
- Reset: pc_r = reset_vec_i & ~3; epoch_r = 0; out_cnt = 0. While rst_n is low: ic_req_valid_o = 0 and ic_req_pc_o = pc_r.
- sel_pc (combinational) = be_redir_pc_i if be_redir_i; else bp_redir_pc_i if bp_redir_i; else pc_r. Bits [1:0] are cleared.
- ic_req_pc_o = sel_pc. A redirect target is issued in the same cycle it arrives (zero latency).
- ic_req_mask_o[i] = 1 when i >= sel_pc[log2(FETCH_BYTES)-1:2].
- ic_req_epoch_o = epoch_r + 1 if any redirect is asserted this cycle, else epoch_r.
- ic_req_valid_o = !stall_i && (out_cnt < MAX_OUTSTANDING || be_redir_i).
  - There is no same-cycle credit bypass from ic_resp_done_i.
  - The request is not sticky: it may change or drop whenever a redirect or stall occurs, and the icache must not rely on it being stable.
- fire = valid & ready.
- pc_r next:
  - on fire: (sel_pc with low log2(FETCH_BYTES) bits cleared) + FETCH_BYTES, wrapping modulo 2^PC_W;
  - else on any redirect: sel_pc;
  - else hold.
- epoch_r next: increments, wrapping, on any redirect cycle. Simultaneous be and bp redirects increment it once.
- out_cnt next:
  - when be_redir_i is asserted: fire ? 1 : 0. In-flight requests are flushed and their credits discarded.
  - otherwise: out_cnt + fire - ic_resp_done_i.
  - ic_resp_done_i with out_cnt == 0 (and no fire) is ignored; the count saturates at 0 and an assertion flags it.
- bp_redir_i does not flush: out_cnt is preserved, and stale responses are filtered downstream by epoch.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_req_o[31:0] and perf_block_o[31:0].
  - perf_req_o counts fires.
  - perf_block_o counts cycles that are not reset, have no redirect, and are either stall_i, credit-blocked, or valid && !ready.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- reset_vec_i=0x8000_0002, release reset, ready=1, done pulsed every cycle -> pc 0x80000000, 0x80000010, 0x80000020; mask 4'b1111; epoch 0.
- be_redir_i with pc 0x80001008 while ready=1 -> same-cycle pc 0x80001008, mask 4'b1100, epoch 1, ic_flush_o=1; next pc 0x80001010; out_cnt=1.
- Same cycle be_redir_pc_i=0x100 and bp_redir_pc_i=0x200 -> pc_o 0x100, epoch +1 (once), next pc 0x110.
- MAX_OUTSTANDING=2, ready=1, no done -> two fires, then valid=0; one done pulse -> valid=1 the following cycle, not the same cycle.
- ready=0 for 3 cycles -> pc_o stable at 0x80000020; bp_redir 0x4000 on cycle 2 -> pc_o 0x4000 that cycle, pc_r=0x4000, out_cnt unchanged.
- reset_vec_i=0xFFFF_FFFF_FFFF_FFF8 -> pc 0x...FFF8, mask 4'b1100; after fire next pc 0x0.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-block PC generator with redirect arbitration, epoch tagging and icache credit limiting.
// Optional FETCH_PERF_CNT_EN adds fire and blocked-cycle counters.
module fetch_pc_gen #(
  parameter int PC_W            = 64,
  parameter int FETCH_BYTES     = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int EPOCH_W         = 2,
  localparam int SLOTS          = FETCH_BYTES / 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    reset_vec_i,
  input  logic               be_redir_i,
  input  logic [PC_W-1:0]    be_redir_pc_i,
  input  logic               bp_redir_i,
  input  logic [PC_W-1:0]    bp_redir_pc_i,
  input  logic               stall_i,
  output logic               ic_req_valid_o,
  input  logic               ic_req_ready_i,
  output logic [PC_W-1:0]    ic_req_pc_o,
  output logic [SLOTS-1:0]   ic_req_mask_o,
  output logic [EPOCH_W-1:0] ic_req_epoch_o,
  output logic               ic_flush_o,
  input  logic               ic_resp_done_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_req_o,
  output logic [31:0]        perf_block_o
`endif
);
  localparam int OFF_W = $clog2(FETCH_BYTES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [PC_W-1:0]    pc_r, raw_pc, sel_pc, blk_next;
  logic [EPOCH_W-1:0] epoch_r;
  logic [CNT_W-1:0]   out_cnt;
  logic               be, bp, redir, fire, credit_ok, done_eff;
  // Redirects are ignored while in reset so the request port shows the boot PC.
  assign be        = rst_n & be_redir_i;
  assign bp        = rst_n & bp_redir_i;
  assign redir     = be | bp;
  assign raw_pc    = be ? be_redir_pc_i : bp ? bp_redir_pc_i : pc_r;
  assign sel_pc    = {raw_pc[PC_W-1:2], 2'b00};
  assign blk_next  = {sel_pc[PC_W-1:OFF_W], {OFF_W{1'b0}}} + PC_W'(FETCH_BYTES);
  assign credit_ok = out_cnt < CNT_W'(MAX_OUTSTANDING);
  assign ic_req_valid_o = rst_n & ~stall_i & (credit_ok | be);
  assign ic_req_pc_o    = sel_pc;
  assign ic_req_epoch_o = epoch_r + EPOCH_W'(redir);
  assign ic_flush_o     = be_redir_i;
  assign fire           = ic_req_valid_o & ic_req_ready_i;
  assign done_eff       = ic_resp_done_i & ((out_cnt != '0) | fire);
  for (genvar i = 0; i < SLOTS; i++) begin : g_mask
    assign ic_req_mask_o[i] = OFF_W'(i * 4) >= sel_pc[OFF_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= {reset_vec_i[PC_W-1:2], 2'b00};
      epoch_r <= '0;
      out_cnt <= '0;
    end else begin
      pc_r    <= fire ? blk_next : redir ? sel_pc : pc_r;
      epoch_r <= ic_req_epoch_o;
      out_cnt <= be ? CNT_W'(fire) : out_cnt + CNT_W'(fire) - CNT_W'(done_eff);
    end
  end
  credit_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ic_resp_done_i && !be_redir_i && out_cnt == '0 && !fire))
    else $error("credit underflow: done with no request in flight");
`ifdef FETCH_PERF_CNT_EN
  logic blocked;
  assign blocked = ~redir & (stall_i | ~credit_ok | (ic_req_valid_o & ~ic_req_ready_i));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_req_o   <= '0;
      perf_block_o <= '0;
    end else begin
      perf_req_o   <= perf_req_o + 32'(fire && perf_req_o != '1);
      perf_block_o <= perf_block_o + 32'(blocked && perf_block_o != '1);
    end
  end
`endif
endmodule
